zetas_seq_ctrl: RTL
===================

ZETAS_SEQ_CTRL -- requirements
Module: zetas_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, twiddle ROM address width.
REQ-002 SHALL have parameter LAYER_GAP, default 2, idle cycles between layers (range 0..15).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start_i  input  1  starts a transform; sampled only in IDLE.
REQ-006 SHALL have port selKD_i  input  1  Kyber(1) or Dilithium(0); latched on the accepted start.
REQ-007 SHALL have port selNTT_i  input  1  NTT(1) or InvNTT(0); latched on the accepted start.
REQ-008 SHALL have port ready_i  input  1  datapath can accept a twiddle request this cycle.
REQ-009 SHALL have port abort_i  input  1  terminates the transform and returns to IDLE.
REQ-010 SHALL have port rom_valid_o  output  1  twiddle ROM request valid.
REQ-011 SHALL have port rom_selKD_o / rom_selNTT_o  output  1 each  latched mode bits.
REQ-012 SHALL have port rom_addrX_o  output  ADDR_WIDTH  Kyber second-butterfly index; 0 for Dilithium.
REQ-013 SHALL have port rom_addrY_o  output  ADDR_WIDTH  first-butterfly twiddle index.
REQ-014 SHALL have port layer_o  output  3  current layer.
REQ-015 SHALL have port busy_o  output  1  high in RUN, GAP and DONE.
REQ-016 SHALL have port layer_done_o / done_o  output  1 each  single-cycle pulses.

Function
REQ-017 SHALL implement states IDLE, RUN, GAP and DONE.
REQ-018 SHALL go IDLE->RUN on start_i, with layer=0 and cycle counter c=0; start_i outside IDLE SHALL be ignored.
REQ-019 SHALL set rom_valid_o = (state==RUN) & ready_i, combinationally; c SHALL advance only when rom_valid_o=1, and address outputs SHALL hold while ready_i=0.
REQ-020 SHALL use these layer parameters: Dilithium 8 layers (0..7), c 0..127, butterfly b=c; Kyber 7 layers (0..6), c 0..63, b0=c, b1=c+64.
REQ-021 SHALL compute the twiddle index as follows:
- Dilithium NTT: k=(1<<l)+(b>>(7-l)).
- Dilithium InvNTT: k=(256>>l)-1-(b>>l).
- Kyber NTT: k=(1<<l)+(b>>(7-l)).
- Kyber InvNTT: k=(128>>l)-1-(b>>(l+1)).
REQ-022 SHALL drive rom_addrY_o=k(b or b0) and rom_addrX_o=k(b1) for Kyber, so Kyber indices are always <128 with bit 7 =0.
REQ-023 SHALL NOT negate twiddles for InvNTT; the block sequences indices only.
REQ-024 SHALL, on the accepted last request of a layer, pulse layer_done_o in the same cycle and then:
- go to DONE if it was the last layer;
- otherwise go to GAP, or straight to RUN with layer+1 and c=0 when LAYER_GAP=0.
REQ-025 SHALL keep GAP for exactly LAYER_GAP cycles with rom_valid_o=0, then enter RUN with layer+1 and c=0.
REQ-026 SHALL stay in DONE for exactly one cycle with done_o=1, then return to IDLE.
REQ-027 SHALL make abort_i=1 in any non-IDLE state force IDLE on the next edge, with no done_o; abort_i SHALL take priority over ready_i and the layer end.
REQ-028 SHALL, with ready_i held at 1, take 1 (start) + Kyber 448+6*LAYER_GAP or Dilithium 1024+7*LAYER_GAP cycles before DONE.

Reset
REQ-029 SHALL, on rst_i=1 at an edge, force state=IDLE, c=0, layer=0 and latched modes=0; rst_i SHALL override start_i and abort_i.
REQ-030 SHALL hold these output values during and after reset: rom_valid_o=0, addresses=0, layer_o=0, busy_o=0, layer_done_o=0, done_o=0.
REQ-031 SHALL, when reset occurs mid-transform, issue no further requests, and a subsequent start_i SHALL restart from layer 0.

Verification
REQ-032 SHALL cover Dilithium NTT with ready_i=1 and LAYER_GAP=2 -> layer 0: 128 requests with addrY=1; layer 7, b=5: addrY=133; done_o at cycle 1039 after start.
REQ-033 SHALL cover Kyber NTT -> layer 0, c=0: addrY=1, addrX=1; layer 1, c=0: addrY=2, addrX=3; layer 6, c=3: addrY=65, addrX=97; done_o at cycle 461.
REQ-034 SHALL cover Kyber InvNTT and Dilithium InvNTT -> Kyber layer 0, c=0: addrY=127, addrX=95; Dilithium layer 0, b=0: addrY=255; Dilithium layer 7, all b: addrY=1.
REQ-035 SHALL cover ready_i toggling randomly in Dilithium NTT -> the address sequence is identical to the stall-free run, with exactly 1024 valid cycles.
REQ-036 SHALL cover abort_i in layer 3 and rst_i mid-GAP -> IDLE on the next edge, no done_o, rom_valid_o=0; a new start_i begins at layer 0, c=0.
REQ-037 SHALL cover start_i while busy, and LAYER_GAP=0 -> the start is ignored; layers run back-to-back with no GAP cycles.

Source files
------------

// File: rtl/zetas_seq_ctrl.sv
// Twiddle-index sequencer for a shared Kyber/Dilithium NTT datapath.
// Walks layers and butterfly counters and issues one ROM index request per accepted cycle.
module zetas_seq_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int LAYER_GAP  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  selKD_i,
  input  logic                  selNTT_i,
  input  logic                  ready_i,
  input  logic                  abort_i,
  output logic                  rom_valid_o,
  output logic                  rom_selKD_o,
  output logic                  rom_selNTT_o,
  output logic [ADDR_WIDTH-1:0] rom_addrX_o,
  output logic [ADDR_WIDTH-1:0] rom_addrY_o,
  output logic [2:0]            layer_o,
  output logic                  busy_o,
  output logic                  layer_done_o,
  output logic                  done_o,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LAST = (LAYER_GAP > 0) ? 4'(LAYER_GAP - 1) : 4'd0;

  state_t     state_q;
  logic [6:0] c_q;
  logic [2:0] layer_q;
  logic [3:0] gap_q;
  logic       kyber_q;
  logic       ntt_q;
  logic       busy_q;
  logic       done_q;

  logic       run_act;
  logic       last_c;
  logic       last_layer;
  logic [8:0] k_y;
  logic [8:0] k_x;

  // Twiddle index for layer l and butterfly b; 9 bits so 256>>l fits before the subtraction.
  function automatic logic [8:0] twiddle_idx(input logic       kyber,
                                             input logic       ntt,
                                             input logic [2:0] l,
                                             input logic [7:0] b);
    logic [8:0] bx;
    logic [8:0] r;
    bx = {1'b0, b};
    if (ntt)
      r = (9'd1 << l) + (bx >> (3'd7 - l));
    else if (!kyber)
      r = (9'd256 >> l) - 9'd1 - (bx >> l);
    else
      r = (9'd128 >> l) - 9'd1 - (bx >> ({1'b0, l} + 4'd1));
    return r;
  endfunction

  // Handshake: rom_valid_o is raised only in RUN while ready_i is high, so every valid
  // cycle is a completed transfer; the counter advances on exactly those cycles and the
  // address outputs hold while ready_i is low.
  assign run_act     = (state_q == RUN) && !rst_i;
  assign rom_valid_o = run_act && ready_i;

  assign last_c     = kyber_q ? (c_q == 7'd63) : (c_q == 7'd127);
  assign last_layer = kyber_q ? (layer_q == 3'd6) : (layer_q == 3'd7);

  assign layer_done_o = rom_valid_o && last_c && !abort_i;

  // Kyber pairs butterfly c with c+64; Dilithium uses only the Y port.
  assign k_y = twiddle_idx(kyber_q, ntt_q, layer_q, {1'b0, c_q});
  assign k_x = twiddle_idx(1'b1, ntt_q, layer_q, {2'b01, c_q[5:0]});

  assign rom_addrY_o = run_act ? ADDR_WIDTH'(k_y) : '0;
  assign rom_addrX_o = (run_act && kyber_q) ? ADDR_WIDTH'(k_x) : '0;

  assign rom_selKD_o  = kyber_q;
  assign rom_selNTT_o = ntt_q;
  assign layer_o      = layer_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign dbg_state_o  = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      c_q     <= '0;
      layer_q <= '0;
      gap_q   <= '0;
      kyber_q <= 1'b0;
      ntt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if ((state_q != IDLE) && abort_i) begin
      state_q <= IDLE;
      c_q     <= '0;
      layer_q <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= RUN;
            c_q     <= '0;
            layer_q <= '0;
            kyber_q <= selKD_i;
            ntt_q   <= selNTT_i;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (rom_valid_o) begin
            if (!last_c) begin
              c_q <= c_q + 7'd1;
            end else if (last_layer) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (LAYER_GAP == 0) begin
              layer_q <= layer_q + 3'd1;
              c_q     <= '0;
            end else begin
              state_q <= GAP;
              gap_q   <= '0;
            end
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= RUN;
            layer_q <= layer_q + 3'd1;
            c_q     <= '0;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          layer_q <= '0;
          c_q     <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
